trace_beat_packer: RTL and testbench

- Upstream stage of the role's 512-bit trace AXI-Stream master output.
- Collects 64-bit trace records from the core-side trace source and packs 8 records into each 512-bit beat.
- Generates tkeep and tlast for every beat.
- Flushes partial beats on record-burst end, on idle timeout, or on software request, so trace never stalls indefinitely in the packer.

---
 rtl/trace_beat_packer.sv | 126 ++++++++++++
 tb/tb_trace_beat_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_beat_packer.sv
// Packs IN_W-bit trace records into OUT_W-bit AXI-Stream beats, flushing partial
// beats on burst end, idle timeout or software request.
module trace_beat_packer #(
    parameter int IN_W    = 64,
    parameter int OUT_W   = 512,
    parameter int TIMEOUT = 256
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_trace_tvalid,
    output logic               s_trace_tready,
    input  logic [IN_W-1:0]    s_trace_tdata,
    input  logic               s_trace_tlast,
    input  logic               flush_req,
    output logic               m_axis_trace_tvalid,
    input  logic               m_axis_trace_tready,
    output logic [OUT_W-1:0]   m_axis_trace_tdata,
    output logic [OUT_W/8-1:0] m_axis_trace_tkeep,
    output logic               m_axis_trace_tlast,
    output logic [31:0]        stat_beats
);

    localparam int LANES = OUT_W / IN_W;
    localparam int LB    = IN_W / 8;
    localparam int CW    = $clog2(LANES + 1);
    localparam int IW    = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LANES_CNT = CW'(LANES);

    logic [IN_W-1:0]    lane_q [LANES];
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_after;
    logic [IW-1:0]      idle;
    logic [IW-1:0]      idle_next;
    logic               flush_pending;
    logic               flush_last;
    logic               accept;
    logic               transfer;
    logic               any_trig;
    logic               last_trig;
    logic [OUT_W-1:0]   beat_data;
    logic [OUT_W/8-1:0] beat_keep;

    assign s_trace_tready = !areset && !flush_pending && (cnt < LANES_CNT);
    assign accept         = s_trace_tvalid && s_trace_tready;
    assign transfer       = flush_pending && (!m_axis_trace_tvalid || m_axis_trace_tready);
    assign cnt_after      = cnt + CW'(accept);

    always_comb begin
        idle_next = idle;
        if (accept || transfer)
            idle_next = '0;
        else if (cnt != '0 && !flush_pending && idle != IDLE_MAX)
            idle_next = idle + IW'(1);
    end

    // A full beat alone yields tlast=0; any other trigger, even coincident, forces tlast=1.
    always_comb begin
        last_trig = 1'b0;
        any_trig  = 1'b0;
        if (cnt_after != '0) begin
            last_trig = (accept && s_trace_tlast)
                     || (!flush_pending && idle_next == IDLE_MAX)
                     || flush_req;
            any_trig  = last_trig || (accept && cnt_after == LANES_CNT);
        end
    end

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (CW'(i) < cnt) begin
                beat_data[i*IN_W +: IN_W] = lane_q[i];
                beat_keep[i*LB +: LB]     = '1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < LANES; i++)
                lane_q[i] <= '0;
            cnt                 <= '0;
            idle                <= '0;
            flush_pending       <= 1'b0;
            flush_last          <= 1'b0;
            m_axis_trace_tvalid <= 1'b0;
            m_axis_trace_tdata  <= '0;
            m_axis_trace_tkeep  <= '0;
            m_axis_trace_tlast  <= 1'b0;
            stat_beats          <= '0;
        end else begin
            idle <= idle_next;
            if (transfer) begin
                cnt           <= '0;
                flush_pending <= 1'b0;
                flush_last    <= 1'b0;
            end else begin
                if (accept) begin
                    for (int unsigned i = 0; i < LANES; i++)
                        if (CW'(i) == cnt)
                            lane_q[i] <= s_trace_tdata;
                    cnt <= cnt_after;
                end
                if (any_trig)
                    flush_pending <= 1'b1;
                if (last_trig)
                    flush_last <= 1'b1;
            end

            if (transfer) begin
                m_axis_trace_tvalid <= 1'b1;
                m_axis_trace_tdata  <= beat_data;
                m_axis_trace_tkeep  <= beat_keep;
                m_axis_trace_tlast  <= flush_last;
            end else if (m_axis_trace_tready) begin
                m_axis_trace_tvalid <= 1'b0;
            end

            if (m_axis_trace_tvalid && m_axis_trace_tready)
                stat_beats <= stat_beats + 32'd1;
        end
    end

endmodule

// File: tb/tb_trace_beat_packer.sv
// Scoreboard bench for trace_beat_packer: directed bursts push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_trace_beat_packer;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         s_trace_tvalid = 1'b0;
    logic         s_trace_tready;
    logic [63:0]  s_trace_tdata = '0;
    logic         s_trace_tlast = 1'b0;
    logic         flush_req = 1'b0;
    logic         m_axis_trace_tvalid;
    logic         m_axis_trace_tready = 1'b0;
    logic [511:0] m_axis_trace_tdata;
    logic [63:0]  m_axis_trace_tkeep;
    logic         m_axis_trace_tlast;
    logic [31:0]  stat_beats;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_beats = 0;

    localparam logic [63:0] KEEP8 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEEP5 = 64'h0000_00FF_FFFF_FFFF;
    localparam logic [63:0] KEEP3 = 64'h0000_0000_00FF_FFFF;
    localparam logic [63:0] KEEP2 = 64'h0000_0000_0000_FFFF;

    trace_beat_packer #(.IN_W(64), .OUT_W(512), .TIMEOUT(16)) dut (
        .aclk                (aclk),
        .areset              (areset),
        .s_trace_tvalid      (s_trace_tvalid),
        .s_trace_tready      (s_trace_tready),
        .s_trace_tdata       (s_trace_tdata),
        .s_trace_tlast       (s_trace_tlast),
        .flush_req           (flush_req),
        .m_axis_trace_tvalid (m_axis_trace_tvalid),
        .m_axis_trace_tready (m_axis_trace_tready),
        .m_axis_trace_tdata  (m_axis_trace_tdata),
        .m_axis_trace_tkeep  (m_axis_trace_tkeep),
        .m_axis_trace_tlast  (m_axis_trace_tlast),
        .stat_beats          (stat_beats)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_beat(input logic [63:0] first, input int n, input logic [63:0] keep,
                             input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++)
            b.data[i*64 +: 64] = first + 64'(i);
        b.keep = keep;
        b.last = last;
        exp_q.push_back(b);
        exp_beats++;
    endtask

    // Issues one record starting just after a rising edge; returns just after its accept edge.
    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        s_trace_tvalid = 1'b1;
        s_trace_tdata  = d;
        s_trace_tlast  = l;
        @(negedge aclk);
        while (!s_trace_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("send_ready", 64'(s_trace_tready), 64'd1);
        @(posedge aclk);
        #1;
        s_trace_tvalid = 1'b0;
        s_trace_tlast  = 1'b0;
    endtask

    task automatic send_run(input logic [63:0] first, input int n, input logic last_on_end);
        for (int i = 0; i < n; i++)
            send(first + 64'(i), last_on_end && (i == n - 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_trace_tvalid) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    always @(negedge aclk) begin
        if (!areset && m_axis_trace_tvalid && m_axis_trace_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data[63:0]=%0h keep=%0h last=%0b expected none",
                         m_axis_trace_tdata[63:0], m_axis_trace_tkeep, m_axis_trace_tlast);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (m_axis_trace_tdata !== e.data || m_axis_trace_tkeep !== e.keep
                    || m_axis_trace_tlast !== e.last) begin
                    errors++;
                    $display("FAIL beat: got keep=%0h last=%0b data=%0h expected keep=%0h last=%0b data=%0h",
                             m_axis_trace_tkeep, m_axis_trace_tlast, m_axis_trace_tdata,
                             e.keep, e.last, e.data);
                end
            end
        end
    end

    initial begin
        logic [511:0] held;
        int n;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_axis_trace_tvalid), 64'd0);
        check("rst_tready", 64'(s_trace_tready), 64'd0);
        check("rst_tkeep", m_axis_trace_tkeep, 64'd0);
        check("rst_stat", 64'(stat_beats), 64'd0);
        areset = 1'b0;
        m_axis_trace_tready = 1'b1;
        idle_cycles(2);
        check("post_rst_tready", 64'(s_trace_tready), 64'd1);

        // Two full beats, tlast on the 16th record
        push_beat(64'h0, 8, KEEP8, 1'b0);
        push_beat(64'h8, 8, KEEP8, 1'b1);
        send_run(64'h0, 16, 1'b1);
        drain();
        check("stat_two", 64'(stat_beats), 64'd2);

        // Partial beat ended by tlast
        push_beat(64'h20, 3, KEEP3, 1'b1);
        send_run(64'h20, 3, 1'b1);
        drain();

        // Partial beat flushed by idle timeout
        push_beat(64'hA0, 5, KEEP5, 1'b1);
        send_run(64'hA0, 5, 1'b0);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!m_axis_trace_tvalid && n < 100);
        check("timeout_lat_ok", 64'(n >= 15 && n <= 17), 64'd1);
        drain();

        // Backpressure: both buffers fill, then drain back-to-back
        m_axis_trace_tready = 1'b0;
        push_beat(64'h100, 8, KEEP8, 1'b0);
        push_beat(64'h108, 8, KEEP8, 1'b0);
        send_run(64'h100, 16, 1'b0);
        @(negedge aclk);
        check("bp_tready_low", 64'(s_trace_tready), 64'd0);
        check("bp_tvalid", 64'(m_axis_trace_tvalid), 64'd1);
        held = m_axis_trace_tdata;
        repeat (4) @(negedge aclk);
        check("bp_hold_lane0", m_axis_trace_tdata[63:0], held[63:0]);
        check("bp_hold_lane7", m_axis_trace_tdata[511:448], 64'h107);
        check("bp_still_stalled", 64'(s_trace_tready), 64'd0);
        @(posedge aclk);
        #1;
        m_axis_trace_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("bp_back_to_back", 64'(m_axis_trace_tvalid), 64'd1);
        drain();

        // flush_req with empty buffer, then after two records
        flush_req = 1'b1;
        idle_cycles(1);
        flush_req = 1'b0;
        idle_cycles(5);
        check("flush_empty_novalid", 64'(m_axis_trace_tvalid), 64'd0);
        push_beat(64'h300, 2, KEEP2, 1'b1);
        send_run(64'h300, 2, 1'b0);
        flush_req = 1'b1;
        idle_cycles(1);
        flush_req = 1'b0;
        drain();
        check("stat_before_rst", 64'(stat_beats), 64'(exp_beats));

        // Reset with a beat held and four records buffered
        m_axis_trace_tready = 1'b0;
        send_run(64'h400, 12, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        exp_beats = 0;
        check("arst_tvalid", 64'(m_axis_trace_tvalid), 64'd0);
        check("arst_tdata", m_axis_trace_tdata[63:0], 64'd0);
        check("arst_tkeep", m_axis_trace_tkeep, 64'd0);
        check("arst_tlast", 64'(m_axis_trace_tlast), 64'd0);
        check("arst_stat", 64'(stat_beats), 64'd0);
        check("arst_tready", 64'(s_trace_tready), 64'd0);
        idle_cycles(2);
        areset = 1'b0;
        m_axis_trace_tready = 1'b1;
        idle_cycles(20);
        check("arst_discard", 64'(m_axis_trace_tvalid), 64'd0);
        check("arst_stat_after", 64'(stat_beats), 64'd0);
        push_beat(64'h500, 8, KEEP8, 1'b0);
        send_run(64'h500, 8, 1'b0);
        drain();
        check("stat_final", 64'(stat_beats), 64'(exp_beats));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
